// File: rtl/light_dance_seq_pkg.sv
// Shared definitions for the light-dance sequencer.
// Holds the sequencer state encoding, the default widths of the
// rate/pattern/step datapaths, and the width of the light-dance register
// that this sequencer drives.
package light_dance_seq_pkg;

  // Width of the light-dance shift/XOR register (qdata/pdata)
  localparam int LD_REG_W = 8;

  // Default datapath widths
  localparam int DEF_RATE_W = 16;
  localparam int DEF_PAT_W  = 16;
  localparam int DEF_STEP_W = 16;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/light_dance_prescaler.sv
// Step-rate prescaler for the light-dance sequencer.
// Counts enabled cycles and raises tick when the count reaches the
// programmed rate, then restarts from zero. The count is frozen while
// pause is high.
// Ports:
//   clk, arst  - clock and asynchronous active-low reset
//   clear      - synchronous clear of the count (used while seeding)
//   run        - counting enable; tick is only produced while high
//   pause      - freezes the count and suppresses tick
//   rate       - tick period minus one
//   tick       - high on cycles where the register should advance
module light_dance_prescaler #(
  parameter int RATE_W = 16
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              clear,
  input  logic              run,
  input  logic              pause,
  input  logic [RATE_W-1:0] rate,
  output logic              tick
);

  logic [RATE_W-1:0] presc;

  // A tick fires on the cycle the count matches the rate, so a rate of
  // zero ticks on every enabled cycle.
  assign tick = run && !pause && (presc == rate);

  // Count register: restarts after each tick and holds while paused or
  // while the sequencer is outside RUN.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      presc <= '0;
    end else if (clear || tick) begin
      presc <= '0;
    end else if (run && !pause) begin
      presc <= presc + RATE_W'(1);
    end
  end

endmodule

// File: rtl/light_dance_seq.sv
// Light-dance sequencer: control stage in front of the 8-bit light-dance
// shift/XOR register. It seeds the register, then advances it at a
// programmable rate while feeding a repeating serial pattern on din. On
// every cycle where the register must not advance it reloads the
// register's own qdata (q_in) so the value holds.
// Ports:
//   clk, arst          - clock and asynchronous active-low reset
//   start, stop, pause - control requests
//   seed, pattern,
//   pat_len, rate,
//   steps              - run settings, captured when a run starts
//   q_in               - qdata fed back from the register
//   din, load, pdata   - drive of the register
//   busy, tick, done   - status
module light_dance_seq
  import light_dance_seq_pkg::*;
#(
  parameter int RATE_W = DEF_RATE_W,
  parameter int PAT_W  = DEF_PAT_W,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     pause,
  input  logic [LD_REG_W-1:0]      seed,
  input  logic [PAT_W-1:0]         pattern,
  input  logic [$clog2(PAT_W)-1:0] pat_len,
  input  logic [RATE_W-1:0]        rate,
  input  logic [STEP_W-1:0]        steps,
  input  logic [LD_REG_W-1:0]      q_in,
  output logic                     din,
  output logic                     load,
  output logic [LD_REG_W-1:0]      pdata,
  output logic                     busy,
  output logic                     tick,
  output logic                     done
);

  localparam int IDX_W = $clog2(PAT_W);

  seq_state_t state_q, state_d;

  logic [LD_REG_W-1:0] seed_r;
  logic [PAT_W-1:0]    pattern_r;
  logic [IDX_W-1:0]    pat_len_r;
  logic [RATE_W-1:0]   rate_r;
  logic [STEP_W-1:0]   steps_r;

  logic [IDX_W-1:0]    bit_idx;
  logic [STEP_W-1:0]   step_cnt;

  logic                capture;
  logic                last_step;
  logic [IDX_W-1:0]    idx_inc;
  logic [IDX_W-1:0]    idx_next;

  assign capture = (state_q == ST_IDLE) && start && !stop;

  // steps_r of zero means free-running, so no tick is ever the last one.
  assign last_step = (steps_r != '0) && (STEP_W'(step_cnt + 1'b1) == steps_r);

  // A pat_len of zero selects the full pattern, which is exactly the
  // natural wrap of bit_idx since the pattern length is a power of two.
  assign idx_inc  = IDX_W'(bit_idx + 1'b1);
  assign idx_next = ((pat_len_r != '0) && (idx_inc == pat_len_r)) ? '0 : idx_inc;

  light_dance_prescaler #(
    .RATE_W (RATE_W)
  ) u_prescaler (
    .clk   (clk),
    .arst  (arst),
    .clear (state_q == ST_SEED),
    .run   (state_q == ST_RUN),
    .pause (pause),
    .rate  (rate_r),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Run settings are latched once at start so input changes during a run
  // have no effect.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      seed_r    <= '0;
      pattern_r <= '0;
      pat_len_r <= '0;
      rate_r    <= '0;
      steps_r   <= '0;
    end else if (capture) begin
      seed_r    <= seed;
      pattern_r <= pattern;
      pat_len_r <= pat_len;
      rate_r    <= rate;
      steps_r   <= steps;
    end
  end

  // Pattern position and step count: cleared while seeding, advanced on
  // every tick. In free-running mode the step count sticks at all-ones.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      bit_idx  <= '0;
      step_cnt <= '0;
    end else if (state_q == ST_SEED) begin
      bit_idx  <= '0;
      step_cnt <= '0;
    end else if ((state_q == ST_RUN) && tick) begin
      bit_idx <= idx_next;
      if ((steps_r != '0) || (step_cnt != '1)) begin
        step_cnt <= step_cnt + STEP_W'(1);
      end
    end
  end

  // Next state and register drive. Outside a tick the register is fed
  // its own value through the parallel load path so it holds.
  always_comb begin
    state_d = state_q;
    load    = 1'b1;
    pdata   = q_in;
    din     = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_SEED;
        end
      end
      ST_SEED: begin
        busy    = 1'b1;
        pdata   = seed_r;
        state_d = stop ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (tick) begin
          load  = 1'b0;
          pdata = '0;
          din   = pattern_r[bit_idx];
        end
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tick && last_step) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_light_dance_seq.sv
// Closed-loop bench for light_dance_seq: the DUT drives a behavioural
// light-dance register whose qdata is fed back to q_in. Expected register
// values and control outputs come from a reference built on run
// arithmetic (tick every rate+1 active cycles, pattern bit tick mod len).
module tb_light_dance_seq;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pause = 1'b0;
  logic [7:0]  seed = '0;
  logic [15:0] pattern = '0;
  logic [3:0]  pat_len = '0;
  logic [15:0] rate = '0;
  logic [15:0] steps = '0;
  logic [7:0]  qreg = 8'h00;
  logic        din, load, busy, tick, done;
  logic [7:0]  pdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // One advance of the light-dance register.
  function automatic logic [7:0] ld_next(input logic [7:0] q, input logic d);
    return {d, q[7:1]} ^ (q[0] ? 8'hB3 : 8'h00);
  endfunction

  // The light-dance register driven by the DUT.
  always @(posedge clk) begin
    qreg <= load ? pdata : ld_next(qreg, din);
  end

  light_dance_seq #(
    .RATE_W (16),
    .PAT_W  (16),
    .STEP_W (16)
  ) dut (
    .clk     (clk),
    .arst    (arst),
    .start   (start),
    .stop    (stop),
    .pause   (pause),
    .seed    (seed),
    .pattern (pattern),
    .pat_len (pat_len),
    .rate    (rate),
    .steps   (steps),
    .q_in    (qreg),
    .din     (din),
    .load    (load),
    .pdata   (pdata),
    .busy    (busy),
    .tick    (tick),
    .done    (done)
  );

  // Issue a start from IDLE; returns settled inside the SEED cycle.
  task automatic launch(input logic [7:0] s, input logic [15:0] p,
                        input logic [3:0] pl, input int r, input int n);
    @(negedge clk);
    seed = s; pattern = p; pat_len = pl; rate = 16'(r); steps = 16'(n);
    start = 1'b1; stop = 1'b0; pause = 1'b0;
    #1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if ({load, busy, tick, done, din} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL reset_ctl: got %b expected %b", {load, busy, tick, done, din}, 5'b10000);
    end
    checks++;
    if (pdata !== qreg) begin
      errors++;
      $display("[TB] FAIL reset_pdata: got %h expected %h", pdata, qreg);
    end
    @(negedge clk); arst = 1'b1; #1;
    checks++;
    if ({load, busy, tick, done, din} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got %b expected %b", {load, busy, tick, done, din}, 5'b10000);
    end
  endtask

  task automatic test_basic_run();
    logic [7:0] exp_q [4];
    exp_q = '{8'h01, 8'hB3, 8'hEA, 8'h75};
    launch(8'h01, 16'h0000, 4'd0, 0, 3);
    checks++;
    if ({load, busy, tick, done, din, pdata} !== {5'b11000, 8'h01}) begin
      errors++;
      $display("[TB] FAIL basic_seed: got %b/%h expected 11000/01", {load, busy, tick, done, din}, pdata);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (qreg !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL basic_q[%0d]: got %h expected %h", i, qreg, exp_q[i]);
      end
      checks++;
      if ({load, busy, tick, done, din} !== 5'b01100) begin
        errors++;
        $display("[TB] FAIL basic_tick[%0d]: got %b expected 01100", i, {load, busy, tick, done, din});
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({load, busy, tick, done, din, qreg} !== {5'b11010, 8'h75}) begin
      errors++;
      $display("[TB] FAIL basic_done: got %b/%h expected 11010/75", {load, busy, tick, done, din}, qreg);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({load, busy, tick, done, din, qreg} !== {5'b10000, 8'h75}) begin
        errors++;
        $display("[TB] FAIL basic_hold[%0d]: got %b/%h expected 10000/75", i, {load, busy, tick, done, din}, qreg);
      end
    end
  endtask

  task automatic test_pattern_feed();
    launch(8'h00, 16'h0001, 4'd1, 0, 1);
    @(negedge clk); #1;
    checks++;
    if ({load, busy, tick, done, din, qreg} !== {5'b01101, 8'h00}) begin
      errors++;
      $display("[TB] FAIL feed_tick: got %b/%h expected 01101/00", {load, busy, tick, done, din}, qreg);
    end
    @(negedge clk); #1;
    checks++;
    if ({load, busy, tick, done, din, qreg} !== {5'b11010, 8'h80}) begin
      errors++;
      $display("[TB] FAIL feed_done: got %b/%h expected 11010/80", {load, busy, tick, done, din}, qreg);
    end
    @(negedge clk); #1;
  endtask

  // Back-to-back randomized runs; start and run settings toggle randomly
  // while busy and must have no effect.
  task automatic test_random_runs(input int nruns);
    logic [7:0]  s, exp;
    logic [15:0] p;
    logic [3:0]  pl;
    logic        is_tick, d;
    int r, n, len, ticks, total;
    for (int k = 0; k < nruns; k++) begin
      s = 8'($urandom); p = 16'($urandom); pl = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 4); n = $urandom_range(1, 6);
      len = (pl == 0) ? 16 : int'(pl);
      total = n * (r + 1);
      launch(s, p, pl, r, n);
      checks++;
      if ({load, busy, tick, done, din, pdata} !== {5'b11000, s}) begin
        errors++;
        $display("[TB] FAIL rand_seed run %0d: got %b/%h expected 11000/%h", k, {load, busy, tick, done, din}, pdata, s);
      end
      exp = s; ticks = 0;
      for (int c = 0; c < total; c++) begin
        @(negedge clk);
        start = 1'($urandom); seed = 8'($urandom); pattern = 16'($urandom);
        pat_len = 4'($urandom); rate = 16'($urandom); steps = 16'($urandom);
        #1;
        is_tick = ((c % (r + 1)) == r);
        d = is_tick ? p[ticks % len] : 1'b0;
        checks++;
        if (qreg !== exp) begin
          errors++;
          $display("[TB] FAIL rand_q run %0d cyc %0d: got %h expected %h", k, c, qreg, exp);
        end
        checks++;
        if ({load, busy, tick, done, din} !== {~is_tick, 1'b1, is_tick, 1'b0, d}) begin
          errors++;
          $display("[TB] FAIL rand_ctl run %0d cyc %0d: got %b expected %b", k, c,
                   {load, busy, tick, done, din}, {~is_tick, 1'b1, is_tick, 1'b0, d});
        end
        if (is_tick) begin
          exp = ld_next(exp, d);
          ticks++;
        end
      end
      @(negedge clk); start = 1'($urandom); #1;
      checks++;
      if ({load, busy, tick, done, din, qreg} !== {5'b11010, exp}) begin
        errors++;
        $display("[TB] FAIL rand_done run %0d: got %b/%h expected 11010/%h", k, {load, busy, tick, done, din}, qreg, exp);
      end
      @(negedge clk); start = 1'b0; #1;
      checks++;
      if ({load, busy, tick, done, din, qreg} !== {5'b10000, exp}) begin
        errors++;
        $display("[TB] FAIL rand_idle run %0d: got %b/%h expected 10000/%h", k, {load, busy, tick, done, din}, qreg, exp);
      end
    end
  endtask

  // Pause mid-run freezes the phase; the run is then aborted with stop.
  task automatic test_pause_stop();
    logic [7:0]  s, exp;
    logic [15:0] p;
    logic        is_tick, d;
    int active, ticks;
    s = 8'($urandom) | 8'h01; p = 16'($urandom);
    launch(s, p, 4'd0, 3, 0);
    exp = s; active = 0; ticks = 0;
    for (int c = 0; c < 31; c++) begin
      @(negedge clk);
      pause = (c >= 5 && c < 15);
      stop  = (c == 30);
      #1;
      is_tick = !pause && ((active % 4) == 3);
      d = is_tick ? p[ticks % 16] : 1'b0;
      checks++;
      if ({load, busy, tick, done, din, qreg} !== {~is_tick, 1'b1, is_tick, 1'b0, d, exp}) begin
        errors++;
        $display("[TB] FAIL pause_cyc %0d: got %b/%h expected %b/%h", c, {load, busy, tick, done, din}, qreg,
                 {~is_tick, 1'b1, is_tick, 1'b0, d}, exp);
      end
      if (!pause) active++;
      if (is_tick) begin
        exp = ld_next(exp, d);
        ticks++;
      end
    end
    pause = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); stop = 1'b0; #1;
      checks++;
      if ({load, busy, tick, done, din, qreg} !== {5'b10000, exp}) begin
        errors++;
        $display("[TB] FAIL stop_idle[%0d]: got %b/%h expected 10000/%h", i, {load, busy, tick, done, din}, qreg, exp);
      end
    end
  endtask

  task automatic test_stop_in_seed();
    logic [7:0] s;
    s = 8'($urandom);
    launch(s, 16'($urandom), 4'd0, 2, 0);
    stop = 1'b1; #1;
    checks++;
    if ({load, busy, tick, done, din, pdata} !== {5'b11000, s}) begin
      errors++;
      $display("[TB] FAIL seed_stop_ctl: got %b/%h expected 11000/%h", {load, busy, tick, done, din}, pdata, s);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); stop = 1'b0; #1;
      checks++;
      if ({load, busy, tick, done, din, qreg} !== {5'b10000, s}) begin
        errors++;
        $display("[TB] FAIL seed_stop_idle[%0d]: got %b/%h expected 10000/%h", i, {load, busy, tick, done, din}, qreg, s);
      end
    end
  endtask

  task automatic test_start_stop_idle();
    logic [7:0] held;
    held = qreg;
    @(negedge clk); seed = 8'hA5; start = 1'b1; stop = 1'b1; #1;
    @(negedge clk); start = 1'b0; stop = 1'b0; #1;
    checks++;
    if ({load, busy, tick, done, din, qreg} !== {5'b10000, held}) begin
      errors++;
      $display("[TB] FAIL start_stop_idle: got %b/%h expected 10000/%h", {load, busy, tick, done, din}, qreg, held);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0]  s, exp;
    logic [15:0] p;
    s = 8'($urandom); p = 16'($urandom);
    launch(s, p, 4'd0, 0, 0);
    exp = s;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({tick, qreg} !== {1'b1, exp}) begin
        errors++;
        $display("[TB] FAIL areset_run[%0d]: got %b/%h expected 1/%h", c, tick, qreg, exp);
      end
      exp = ld_next(exp, p[c]);
    end
    @(negedge clk); #1;
    arst = 1'b0; #1;
    checks++;
    if ({load, busy, tick, done, din, pdata, qreg} !== {5'b10000, exp, exp}) begin
      errors++;
      $display("[TB] FAIL areset_mid: got %b/%h/%h expected 10000/%h/%h", {load, busy, tick, done, din}, pdata, qreg, exp, exp);
    end
    @(negedge clk); arst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      checks++;
      if ({load, busy, tick, done, din, qreg} !== {5'b10000, exp}) begin
        errors++;
        $display("[TB] FAIL areset_idle[%0d]: got %b/%h expected 10000/%h", i, {load, busy, tick, done, din}, qreg, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: bench still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] light_dance_seq closed-loop bench");
    test_reset();
    test_basic_run();
    test_pattern_feed();
    test_random_runs(20);
    test_pause_stop();
    test_stop_in_seed();
    test_start_stop_idle();
    test_async_reset();
    test_random_runs(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
